// File: rtl/hazard_ctrl_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit_if
//
// Bundles the pipeline-status inputs and pipeline-control outputs of the
// hazard control unit. Signal names match the MIPS datapath they connect to.
//
// Modports:
//   master : datapath / cache side (drives status, receives control)
//   slave  : hazard_ctrl_unit (receives status, drives control)
//
// Status (master -> slave):
//   ihit, dhit                : cache completion strobes
//   dmem_req_EX_MEM           : dREN|dWEN of the EX/MEM instruction
//   branch_taken_EX_MEM       : resolved taken branch in EX/MEM
//   jump_IF_ID, jr_IF_ID      : J/JAL and JR decoded in IF/ID
//   halt_MEM_WB               : HALT reached MEM/WB
//   dREN_ID_EX, Rt_ID_EX      : load in ID/EX and its destination
//   Rs_IF_ID, Rt_IF_ID        : source registers of the IF/ID instruction
// Control (slave -> master):
//   enable, flush [3:0]       : [0]=IF/ID [1]=ID/EX [2]=EX/MEM [3]=MEM/WB
//   pc_en, PCSrc              : PC update enable and next-PC source select
//   stall_cnt, flush_cnt      : performance counters (zero unless enabled)
// -----------------------------------------------------------------------------
interface hazard_ctrl_unit_if #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 16
) ();

   logic             ihit;
   logic             dhit;
   logic             dmem_req_EX_MEM;
   logic             branch_taken_EX_MEM;
   logic             jump_IF_ID;
   logic             jr_IF_ID;
   logic             halt_MEM_WB;
   logic             dREN_ID_EX;
   logic [REG_W-1:0] Rt_ID_EX;
   logic [REG_W-1:0] Rs_IF_ID;
   logic [REG_W-1:0] Rt_IF_ID;

   logic [3:0]       enable;
   logic [3:0]       flush;
   logic             pc_en;
   logic [1:0]       PCSrc;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output ihit, dhit, dmem_req_EX_MEM, branch_taken_EX_MEM, jump_IF_ID, jr_IF_ID,
             halt_MEM_WB, dREN_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID,
      input  enable, flush, pc_en, PCSrc, stall_cnt, flush_cnt
   );

   modport slave (
      input  ihit, dhit, dmem_req_EX_MEM, branch_taken_EX_MEM, jump_IF_ID, jr_IF_ID,
             halt_MEM_WB, dREN_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID,
      output enable, flush, pc_en, PCSrc, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Stateful hazard controller for the 5-stage MIPS pipeline. Produces the
// per-pipeline-register enable/flush vectors, the PC enable and the PC-source
// select from the current cache/hazard status and a small FSM
// (run / load-use wait / memory wait / halted) with a bubble counter.
//
// Decision priority each cycle, highest first:
//   halt > data-memory wait > taken branch > load-use (incl. pending bubbles)
//   > jump / jump-register > normal advance
//
// Ports:
//   CLK : rising-edge clock
//   RST : asynchronous active-high reset; while high the outputs are forced to
//         enable=0000, flush=1111, pc_en=0, PCSrc=00
//   bus : hazard_ctrl_unit_if.slave (status in, control out)
//
// Parameters:
//   REG_W    : register-index width
//   LU_STALL : bubbles inserted per load-use hazard (legal range 1..3)
//   CNT_W    : performance counter width
//
// Optional feature (macro HAZARD_PERF_CNT_EN):
//   defined   : stall_cnt counts cycles with pc_en=0 outside halt, flush_cnt
//               counts cycles where a branch/jump/JR drives flush[2:0];
//               both saturate and clear on RST
//   undefined : both counter outputs are tied to zero, no counter flops
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
   parameter int unsigned REG_W    = 5,
   parameter int unsigned LU_STALL = 1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic              CLK,
   input  logic              RST,
   hazard_ctrl_unit_if.slave bus
);

   typedef enum logic [1:0] {
      StRun,
      StLuWait,
      StMemWait,
      StHalted
   } state_e;

   // The detection cycle is the first bubble, so the counter holds the rest.
   localparam logic [1:0] LuLoad = 2'(LU_STALL - 1);

   state_e     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;

   logic [REG_W-1:0] rt_ex;
   logic [REG_W-1:0] rs_id;
   logic [REG_W-1:0] rt_id;
   logic             ihit;
   logic             lu_hit;
   logic             mem_stall;
   logic             halt_now;

   logic [3:0] enable_c;
   logic [3:0] flush_c;
   logic       pc_en_c;
   logic [1:0] pcsrc_c;

   assign rt_ex = bus.Rt_ID_EX;
   assign rs_id = bus.Rs_IF_ID;
   assign rt_id = bus.Rt_IF_ID;
   assign ihit  = bus.ihit;

   // $zero never carries a real dependency.
   assign lu_hit = bus.dREN_ID_EX && (rt_ex != '0) && ((rt_ex == rs_id) || (rt_ex == rt_id));

   assign mem_stall = bus.dmem_req_EX_MEM && !bus.dhit;
   assign halt_now  = (state_q == StHalted) || bus.halt_MEM_WB;

   // ---------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      enable_c = {4{ihit}};
      flush_c  = 4'b0000;
      pc_en_c  = ihit;
      pcsrc_c  = 2'b00;

      if (halt_now) begin
         state_d  = StHalted;
         cnt_d    = 2'd0;
         enable_c = 4'b0000;
         pc_en_c  = 1'b0;
      end else if (mem_stall) begin
         // Whole pipeline freezes; any pending load-use bubbles are kept for later.
         state_d  = StMemWait;
         enable_c = 4'b0000;
         pc_en_c  = 1'b0;
      end else if (bus.branch_taken_EX_MEM) begin
         // Without ihit the flush is withheld; the branch stays in EX/MEM and retries.
         state_d  = StRun;
         cnt_d    = 2'd0;
         pcsrc_c  = 2'b01;
         flush_c  = {1'b0, {3{ihit}}};
      end else if ((cnt_q != 2'd0) || lu_hit) begin
         // Hold PC and IF/ID, inject a bubble into ID/EX, let the load move on.
         enable_c = {ihit, ihit, ihit, 1'b0};
         flush_c  = 4'b0010;
         pc_en_c  = 1'b0;
         cnt_d    = (cnt_q != 2'd0) ? (cnt_q - 2'd1) : LuLoad;
         state_d  = (cnt_d != 2'd0) ? StLuWait : StRun;
      end else if (bus.jump_IF_ID) begin
         state_d    = StRun;
         pcsrc_c    = 2'b10;
         flush_c[0] = ihit;
      end else if (bus.jr_IF_ID) begin
         state_d    = StRun;
         pcsrc_c    = 2'b11;
         flush_c[0] = ihit;
      end else begin
         state_d = StRun;
      end
   end

   // Reset overrides the outputs immediately, not only at the next edge.
   always_comb begin
      bus.enable = enable_c;
      bus.flush  = flush_c;
      bus.pc_en  = pc_en_c;
      bus.PCSrc  = pcsrc_c;
      if (RST) begin
         bus.enable = 4'b0000;
         bus.flush  = 4'b1111;
         bus.pc_en  = 1'b0;
         bus.PCSrc  = 2'b00;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StRun;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Optional performance counters
   // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             ctrl_flush;

   // A non-zero PCSrc only occurs on branch/jump/JR paths, which flush iff ihit.
   assign ctrl_flush = (pcsrc_c != 2'b00) && ihit;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_en_c && !halt_now && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (ctrl_flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`else
   assign bus.stall_cnt = {CNT_W{1'b0}};
   assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//
// Directed scenarios with hand-computed expectations, followed by randomized
// traffic. A behavioural model (remaining-bubble count, halted flag, counters)
// predicts the outputs every cycle; a single compare process checks them on
// the falling clock edge. Inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

   localparam int unsigned RegW    = 5;
   localparam int unsigned LuStall = 2;
   localparam int unsigned CntW    = 16;

   logic CLK;
   logic RST;

   int n_checks = 0;
   int n_fail   = 0;

   hazard_ctrl_unit_if #(.REG_W(RegW), .CNT_W(CntW)) b ();

   hazard_ctrl_unit #(
      .REG_W   (RegW),
      .LU_STALL(LuStall),
      .CNT_W   (CntW)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic exp_out(input string nm, input logic [3:0] en, input logic [3:0] fl,
                          input logic pc, input logic [1:0] src);
      chk({nm, ".enable"}, 32'(b.enable), 32'(en));
      chk({nm, ".flush"},  32'(b.flush),  32'(fl));
      chk({nm, ".pc_en"},  32'(b.pc_en),  32'(pc));
      chk({nm, ".PCSrc"},  32'(b.PCSrc),  32'(src));
   endtask

   task automatic idle_inputs();
      b.ihit                = 1'b1;
      b.dhit                = 1'b1;
      b.dmem_req_EX_MEM     = 1'b0;
      b.branch_taken_EX_MEM = 1'b0;
      b.jump_IF_ID          = 1'b0;
      b.jr_IF_ID            = 1'b0;
      b.halt_MEM_WB         = 1'b0;
      b.dREN_ID_EX          = 1'b0;
      b.Rt_ID_EX            = '0;
      b.Rs_IF_ID            = '0;
      b.Rt_IF_ID            = '0;
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: bubbles still owed, halted flag, perf counters
   // ---------------------------------------------------------------------------
   int          bub    = 0;
   int          bub_nx = 0;
   bit          hlt    = 1'b0;
   bit          hlt_nx = 1'b0;
   int unsigned sc = 0, sc_nx = 0, fc = 0, fc_nx = 0;
   localparam int unsigned CntMax = (1 << CntW) - 1;

   always @(negedge CLK) begin : cmp
      logic [3:0] xe, xf;
      logic       xp;
      logic [1:0] xs;
      logic       ih, lu, in_halt;
      ih = b.ihit;
      lu = b.dREN_ID_EX && (b.Rt_ID_EX != 0) &&
           ((b.Rt_ID_EX == b.Rs_IF_ID) || (b.Rt_ID_EX == b.Rt_IF_ID));
      in_halt = hlt || b.halt_MEM_WB;
      bub_nx = bub;
      hlt_nx = hlt;
      xe = {4{ih}};
      xf = 4'b0000;
      xp = ih;
      xs = 2'b00;
      if (RST) begin
         xe = 4'b0000; xf = 4'b1111; xp = 1'b0; bub_nx = 0; hlt_nx = 1'b0;
      end else if (in_halt) begin
         xe = 4'b0000; xp = 1'b0; hlt_nx = 1'b1; bub_nx = 0;
      end else if (b.dmem_req_EX_MEM && !b.dhit) begin
         xe = 4'b0000; xp = 1'b0;
      end else if (b.branch_taken_EX_MEM) begin
         xs = 2'b01; xf = ih ? 4'b0111 : 4'b0000; bub_nx = 0;
      end else if (bub > 0 || lu) begin
         xe = {ih, ih, ih, 1'b0}; xf = 4'b0010; xp = 1'b0;
         bub_nx = (bub > 0) ? bub - 1 : int'(LuStall) - 1;
      end else if (b.jump_IF_ID) begin
         xs = 2'b10; xf = {3'b000, ih};
      end else if (b.jr_IF_ID) begin
         xs = 2'b11; xf = {3'b000, ih};
      end
      chk("model.enable", 32'(b.enable), 32'(xe));
      chk("model.flush",  32'(b.flush),  32'(xf));
      chk("model.pc_en",  32'(b.pc_en),  32'(xp));
      chk("model.PCSrc",  32'(b.PCSrc),  32'(xs));
`ifdef HAZARD_PERF_CNT_EN
      chk("model.stall_cnt", 32'(b.stall_cnt), sc);
      chk("model.flush_cnt", 32'(b.flush_cnt), fc);
      sc_nx = sc;
      fc_nx = fc;
      if (!RST && !in_halt && !xp && sc < CntMax) sc_nx = sc + 1;
      if (!RST && xs != 2'b00 && xf[2:0] != 3'b000 && fc < CntMax) fc_nx = fc + 1;
`else
      chk("model.stall_cnt", 32'(b.stall_cnt), 32'd0);
      chk("model.flush_cnt", 32'(b.flush_cnt), 32'd0);
`endif
   end

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         bub <= 0; hlt <= 1'b0; sc <= 0; fc <= 0;
      end else begin
         bub <= bub_nx; hlt <= hlt_nx; sc <= sc_nx; fc <= fc_nx;
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      RST = 1'b1;
      idle_inputs();

      // Reset outputs.
      @(negedge CLK);
      exp_out("reset", 4'b0000, 4'b1111, 1'b0, 2'b00);

      // First cycle after release, no hazards.
      next_cycle();
      RST = 1'b0;
      @(negedge CLK);
      exp_out("release", 4'b1111, 4'b0000, 1'b1, 2'b00);

      // Load-use with LU_STALL=2: detection bubble plus one counted bubble.
      next_cycle();
      b.dREN_ID_EX = 1'b1; b.Rt_ID_EX = 5'd5; b.Rs_IF_ID = 5'd5;
      @(negedge CLK);
      exp_out("lu_bubble1", 4'b1110, 4'b0010, 1'b0, 2'b00);
      next_cycle();
      idle_inputs();
      @(negedge CLK);
      exp_out("lu_bubble2", 4'b1110, 4'b0010, 1'b0, 2'b00);
      next_cycle();
      @(negedge CLK);
      exp_out("lu_done", 4'b1111, 4'b0000, 1'b1, 2'b00);

      // Load into $zero never stalls.
      next_cycle();
      b.dREN_ID_EX = 1'b1; b.Rt_ID_EX = 5'd0; b.Rs_IF_ID = 5'd0;
      @(negedge CLK);
      exp_out("lu_zero", 4'b1111, 4'b0000, 1'b1, 2'b00);

      // Data miss for three cycles, then the hit.
      next_cycle();
      idle_inputs();
      b.dmem_req_EX_MEM = 1'b1; b.dhit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         exp_out("dmiss", 4'b0000, 4'b0000, 1'b0, 2'b00);
         next_cycle();
      end
      b.dhit = 1'b1;
      @(negedge CLK);
      exp_out("dhit", 4'b1111, 4'b0000, 1'b1, 2'b00);

      // Branch beats a simultaneous load-use.
      next_cycle();
      idle_inputs();
      b.branch_taken_EX_MEM = 1'b1;
      b.dREN_ID_EX = 1'b1; b.Rt_ID_EX = 5'd7; b.Rt_IF_ID = 5'd7;
      @(negedge CLK);
      exp_out("branch_lu", 4'b1111, 4'b0111, 1'b1, 2'b01);

      // JR waiting for ihit, then completing.
      next_cycle();
      idle_inputs();
      b.jr_IF_ID = 1'b1; b.ihit = 1'b0;
      @(negedge CLK);
      exp_out("jr_noihit", 4'b0000, 4'b0000, 1'b0, 2'b11);
      next_cycle();
      b.ihit = 1'b1;
      @(negedge CLK);
      exp_out("jr_ihit", 4'b1111, 4'b0001, 1'b1, 2'b11);

      // Branch arriving during the counted bubble takes over.
      next_cycle();
      idle_inputs();
      b.dREN_ID_EX = 1'b1; b.Rt_ID_EX = 5'd3; b.Rs_IF_ID = 5'd3;
      @(negedge CLK);
      exp_out("lu_then_br0", 4'b1110, 4'b0010, 1'b0, 2'b00);
      next_cycle();
      idle_inputs();
      b.branch_taken_EX_MEM = 1'b1;
      @(negedge CLK);
      exp_out("lu_then_br1", 4'b1111, 4'b0111, 1'b1, 2'b01);

      // Reset asserted in the middle of a data miss acts immediately.
      next_cycle();
      idle_inputs();
      b.dmem_req_EX_MEM = 1'b1; b.dhit = 1'b0;
      @(negedge CLK);
      exp_out("pre_rst_miss", 4'b0000, 4'b0000, 1'b0, 2'b00);
      next_cycle();
      RST = 1'b1;
      #1;
      exp_out("mid_rst", 4'b0000, 4'b1111, 1'b0, 2'b00);
      next_cycle();
      RST = 1'b0;
      idle_inputs();
      @(negedge CLK);
      exp_out("post_rst", 4'b1111, 4'b0000, 1'b1, 2'b00);

      // Halt pulse is sticky.
      next_cycle();
      b.halt_MEM_WB = 1'b1;
      @(negedge CLK);
      exp_out("halt", 4'b0000, 4'b0000, 1'b0, 2'b00);
      next_cycle();
      b.halt_MEM_WB = 1'b0;
      b.jump_IF_ID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         exp_out("halted", 4'b0000, 4'b0000, 1'b0, 2'b00);
         next_cycle();
      end

      // Randomized traffic, re-reset per block so halts do not end coverage.
      for (int blk = 0; blk < 6; blk++) begin
         RST = 1'b1;
         idle_inputs();
         next_cycle();
         RST = 1'b0;
         for (int i = 0; i < 300; i++) begin
            b.ihit                = ($urandom_range(0, 3) != 0);
            b.dhit                = ($urandom_range(0, 2) != 0);
            b.dmem_req_EX_MEM     = ($urandom_range(0, 3) == 0);
            b.branch_taken_EX_MEM = ($urandom_range(0, 5) == 0);
            b.jump_IF_ID          = ($urandom_range(0, 7) == 0);
            b.jr_IF_ID            = ($urandom_range(0, 7) == 0);
            b.halt_MEM_WB         = ($urandom_range(0, 249) == 0);
            b.dREN_ID_EX          = ($urandom_range(0, 2) == 0);
            b.Rt_ID_EX            = RegW'($urandom_range(0, 3));
            b.Rs_IF_ID            = RegW'($urandom_range(0, 3));
            b.Rt_IF_ID            = RegW'($urandom_range(0, 3));
            next_cycle();
         end
      end

      @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised, stateful successor to the pipeline hazard unit for the 5-stage MIPS datapath.
- Drives per-register enable/flush vectors (IF/ID, ID/EX, EX/MEM, MEM/WB), PC enable and PC-source select.
- Adds a run/stall/mem-wait/halt FSM, multi-cycle load-use bubbles, jump-register handling and sticky halt.
- Sits between the pipeline registers, the PC and the cache interface (ihit/dhit).

Parameters:
- REG_W, 5, register-index width.
- LU_STALL, 1, load-use bubbles inserted per hazard (legal 1..3).
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- CLK in 1: rising-edge clock.
- RST in 1: asynchronous, active-high reset.
- ihit in 1: instruction fetch complete this cycle.
- dhit in 1: data access complete this cycle.
- dmem_req_EX_MEM in 1: dREN|dWEN of the instruction in EX/MEM.
- branch_taken_EX_MEM in 1: resolved branch taken in EX/MEM.
- jump_IF_ID in 1: J/JAL decoded in IF/ID.
- jr_IF_ID in 1: JR decoded in IF/ID.
- halt_MEM_WB in 1: HALT reached MEM/WB.
- dREN_ID_EX in 1: load in ID/EX.
- Rt_ID_EX in REG_W: load destination.
- Rs_IF_ID in REG_W: source register.
- Rt_IF_ID in REG_W: source register.
- enable out 4: [0]=IF/ID, [1]=ID/EX, [2]=EX/MEM, [3]=MEM/WB.
- flush out 4: same bit order.
- pc_en out 1: PC update enable.
- PCSrc out 2: 00 PC+4, 01 branch target, 10 jump target, 11 register (JR).
- stall_cnt out CNT_W: stall-cycle count (optional feature).
- flush_cnt out CNT_W: control-flush event count (optional feature).

Behaviour:
- Clock and reset: one clock domain (CLK). Reset RST is asynchronous, active-high.
- State register: {RUN, LU_WAIT, MEM_WAIT, HALTED} plus a 2-bit bubble counter. Reset gives state=RUN, counter=0.
- Outputs are combinational from state and inputs. While RST is high: enable=0000, flush=1111, pc_en=0, PCSrc=00.
- Priority, highest first, evaluated every cycle: halt > mem wait > branch > load-use > jump/jr > normal.
- HALTED: entered when halt_MEM_WB=1. Outputs enable=0000, flush=0000, pc_en=0, PCSrc=00. Stays in HALTED until RST.
- MEM_WAIT: entered (or held) when dmem_req_EX_MEM=1 and dhit=0.
  - Outputs enable=0000, pc_en=0.
  - Exit to RUN on the cycle dhit=1. In that cycle the pipeline advances normally, with enable gated by ihit.
- Normal (RUN, no hazard): enable={4{ihit}}, flush=0000, pc_en=ihit, PCSrc=00.
- Branch (branch_taken_EX_MEM=1):
  - PCSrc=01, pc_en=ihit.
  - flush[2:0]=111 when ihit, otherwise 000 and the flush is retried next cycle.
  - Overrides any simultaneous load-use or jump.
- Load-use: dREN_ID_EX=1, Rt_ID_EX!=0, and Rt_ID_EX equals Rs_IF_ID or Rt_IF_ID.
  - Outputs enable[0]=0, pc_en=0, flush[1]=1, enable[3:2]=ihit.
  - Detection cycle counts as bubble 1. Counter loads LU_STALL-1. If non-zero, go to LU_WAIT.
- LU_WAIT: same outputs as load-use. Counter decrements each cycle; return to RUN when it reaches 0.
  - A branch during LU_WAIT wins: apply branch outputs, clear the counter, go to RUN.
- Jump (jump_IF_ID=1): PCSrc=10, flush[0]=ihit, pc_en=ihit.
- JR (jr_IF_ID=1): PCSrc=11, flush[0]=ihit, pc_en=ihit.
  - If the JR's Rs matches a load in ID/EX, the load-use stall takes precedence. JR resolves after the bubbles.
- flush[3] is never asserted outside reset.
- Reset mid-stall: immediately forces RUN, counter 0, and the reset outputs.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each cycle with pc_en=0 outside HALTED.
  - flush_cnt increments on each cycle where any of flush[2:0] is driven by a branch, jump or JR.
  - Both counters saturate at all-ones and clear on RST.
- Undefined: stall_cnt and flush_cnt are tied to 0; no counter flops are synthesised.

Test Plan:
- Reset release with ihit=1 and no hazards: enable=1111, flush=0000, pc_en=1, PCSrc=00 on the first cycle.
- Load-use: dREN_ID_EX=1, Rt_ID_EX=5, Rs_IF_ID=5, LU_STALL=2: two consecutive cycles of enable[0]=0, flush[1]=1, pc_en=0, then normal. Repeat with Rt_ID_EX=0: no stall.
- Data miss: dmem_req_EX_MEM=1, dhit=0 for 3 cycles: enable=0000, pc_en=0 for 3 cycles. The cycle dhit=1 gives enable=1111.
- Branch and load-use together: branch_taken_EX_MEM=1 with a load-use match, ihit=1: PCSrc=01, flush=0111, pc_en=1.
- JR with ihit=0 then ihit=1: flush[0]=0, then 1. PCSrc=11 in both cycles.
- Halt: halt_MEM_WB=1 pulse: pc_en=0, enable=0000 permanently until RST. With HAZARD_PERF_CNT_EN defined, stall_cnt frozen.
